fp32_accumulator: RTL and testbench
===================================

# fp32_accumulator

Sequential FP32 accumulator downstream of the combinational FP32 multiplier in the TPU processing element. It consumes one product per valid/ready handshake and adds it into a running sum with a multi-cycle align/add/normalize FSM. On a term flagged `in_last` it presents the sum with its term count, then clears for the next dot product.

## Interface
- `COUNT_W`, default 16: width of the term counter.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `in_valid`  in  1: a product is presented.
- `in_ready`  out  1: accumulator can accept a product.
- `in_data`  in  32: IEEE-754 single-precision product from the multiplier.
- `in_last`  in  1: final term of the current dot product.
- `out_valid`  out  1: the sum is available.
- `out_ready`  in  1: the consumer takes the sum.
- `out_data`  out  32: accumulated FP32 sum.
- `out_count`  out  COUNT_W: number of terms in the sum. Wraps modulo 2^COUNT_W.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `in_data` and `in_last`, then go to ALIGN.
  - ALIGN, one cycle:
    - Unpack the operand and the accumulator.
    - Exponent field 0 means zero; denormals are flushed to zero.
    - Shift the smaller-exponent 24-bit mantissa (with hidden 1) right by the exponent difference, truncating.
    - A difference of 25 or more makes that mantissa 0.
  - ADD, one cycle:
    - Equal signs: add magnitudes into a 25-bit result.
    - Differing signs: subtract the smaller magnitude from the larger; the result takes the larger operand's sign.
  - NORM, at least one cycle:
    - Bit 24 set: shift right 1 and increment the exponent.
    - Else, bit 23 clear and result nonzero: shift left 1 and decrement the exponent.
    - Exit when bit 23 is set or the result is zero.
    - On exit, write the accumulator, increment the count, then go to OUT if last is latched, otherwise IDLE.
  - OUT: `out_valid`=1. On `out_ready`, clear the accumulator to +0 and the count to 0, then go to IDLE.
- Rounding is truncation (toward zero). There are no guard bits.
- Zero result is always +0, including exact cancellation.
- Exponent overflow (above 254) gives ±Inf, 0x7F800000 or 0xFF800000. Underflow (below 1) gives +0.
- NaN and Inf inputs are not supported. Their result is unspecified but must not hang the FSM.
- `out_data` and `out_count` reflect the accumulator registers at all times; they are meaningful only while `out_valid`=1.

## Timing
- Reset values: state IDLE, accumulator 0x00000000, count 0, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_count`=0.
- Reset mid-operation (any state) returns to IDLE immediately and discards the partial term and the sum.
- Per-term latency:
  - Accept at edge N; ALIGN at N+1, ADD at N+2, NORM at N+3 through N+3+k, where k is the number of shifts.
  - `in_ready` reasserts in cycle N+4+k. For a last term, `out_valid` asserts in that same cycle instead.
- `in_ready` is a pure state decode: no combinational path from `in_valid`, and no input is accepted while busy or in OUT.
- `out_valid` stays high and `out_data` stays stable until `out_ready`. `out_ready` sampled outside OUT is ignored.
- `in_valid` asserted in the same cycle OUT completes is not accepted until the following IDLE cycle.

## Structure
- A shared package `fp32_pkg` holds:
  - `FP32_BIAS`=127, `FP32_EXP_MAX`=255, `FP32_POS_ZERO`, `FP32_POS_INF`;
  - the packed struct `fp32_t` {sign, exp[7:0], frac[22:0]};
  - the FSM state enum `acc_state_e`.
- One sub-module, `fp32_align`: combinational compare/swap and right shift of the smaller operand. It is reusable by a future adder.
- Mantissa arithmetic and normalization stay in the top-level FSM.

## Test plan
- 0x3F800000 (1.0), then 0x40000000 (2.0) with last → `out_data`=0x40400000, `out_count`=2; next IDLE has accumulator +0.
- 0x3FC00000 (1.5), then 0xBFC00000 (-1.5) with last → `out_data`=0x00000000, `out_count`=2.
- 0x3FC00000, then 0xBFBFFFFF with last → 23 NORM left shifts, `out_data`=0x34000000; `in_ready` low for 26 cycles after the second accept.
- 0x7F7FFFFF twice with last → `out_data`=0x7F800000.
- Single 0x40400000 with last, `out_ready` held low 5 cycles → `out_valid` held, `out_data`=0x40400000 stable, `in_ready`=0 throughout; clears one cycle after `out_ready`.
- Reset pulsed during NORM of the second term → all outputs at reset values; a following single 0x3F800000 with last gives 0x3F800000, count 1.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the processing-element arithmetic blocks.
package fp32_pkg;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_MANT_W  = 24;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_ALIGN,
        ACC_ADD,
        ACC_NORM,
        ACC_OUT
    } acc_state_e;

    // Mantissa with hidden one; denormals and zero collapse to 0.
    function automatic logic [FP32_MANT_W-1:0] fp32Mant(input fp32_t x);
        return (x.exp == 8'd0) ? '0 : {1'b1, x.frac};
    endfunction

endpackage

// File: rtl/fp32_align.sv
// Combinational operand alignment: picks the larger-exponent operand and
// right-shifts the other's mantissa (truncating) to the common exponent.
module fp32_align
    import fp32_pkg::*;
(
    input  fp32_t       a,
    input  fp32_t       b,
    output logic        bigSign,
    output logic [7:0]  bigExp,
    output logic [23:0] bigMant,
    output logic        smallSign,
    output logic [23:0] smallMant
);

    logic        swap;
    logic [7:0]  smallExp;
    logic [7:0]  expDiff;
    logic [23:0] smallRaw;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        swap      = b.exp > a.exp;
        bigSign   = swap ? b.sign : a.sign;
        bigExp    = swap ? b.exp  : a.exp;
        bigMant   = swap ? fp32Mant(b) : fp32Mant(a);
        smallSign = swap ? a.sign : b.sign;
        smallExp  = swap ? a.exp  : b.exp;
        smallRaw  = swap ? fp32Mant(a) : fp32Mant(b);
        expDiff   = bigExp - smallExp;
        smallMant = (expDiff >= 8'd25) ? '0 : (smallRaw >> expDiff);
    end

endmodule

// File: rtl/fp32_accumulator.sv
// Sequential FP32 accumulator: align/add/normalize FSM that folds one product
// per handshake into a running sum and emits the sum on the last term.
module fp32_accumulator
    import fp32_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic signed [9:0] EXP_LIMIT = 10'(FP32_EXP_MAX);

    acc_state_e         state;
    fp32_t              opReg;
    fp32_t              accReg;
    logic               lastReg;
    logic [COUNT_W-1:0] countReg;
    logic               inReadyReg;
    logic               outValidReg;

    logic               bigSignR;
    logic               smallSignR;
    logic [7:0]         bigExpR;
    logic [23:0]        bigMantR;
    logic [23:0]        smallMantR;

    logic               sumSign;
    logic signed [9:0]  sumExp;
    logic [24:0]        sumMant;

    logic               alBigSign;
    logic [7:0]         alBigExp;
    logic [23:0]        alBigMant;
    logic               alSmallSign;
    logic [23:0]        alSmallMant;

    logic               addSign;
    logic [24:0]        addMant;
    fp32_t              normResult;

    fp32_align uAlign (
        .a         (opReg),
        .b         (accReg),
        .bigSign   (alBigSign),
        .bigExp    (alBigExp),
        .bigMant   (alBigMant),
        .smallSign (alSmallSign),
        .smallMant (alSmallMant)
    );

    always_comb begin
        addSign = bigSignR;
        addMant = {1'b0, bigMantR} + {1'b0, smallMantR};
        if (bigSignR != smallSignR) begin
            if (bigMantR >= smallMantR) begin
                addMant = {1'b0, bigMantR - smallMantR};
            end else begin
                addSign = smallSignR;
                addMant = {1'b0, smallMantR - bigMantR};
            end
        end
    end

    // Packing of the normalized sum, including the zero/overflow/underflow cases.
    always_comb begin
        normResult = FP32_POS_ZERO;
        if (sumMant != 25'd0) begin
            if (sumExp >= EXP_LIMIT) begin
                normResult = {sumSign, FP32_POS_INF[30:0]};
            end else if (sumExp >= 10'sd1) begin
                normResult = {sumSign, sumExp[7:0], sumMant[22:0]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ACC_IDLE;
            opReg       <= FP32_POS_ZERO;
            accReg      <= FP32_POS_ZERO;
            lastReg     <= 1'b0;
            countReg    <= '0;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            bigSignR    <= 1'b0;
            smallSignR  <= 1'b0;
            bigExpR     <= '0;
            bigMantR    <= '0;
            smallMantR  <= '0;
            sumSign     <= 1'b0;
            sumExp      <= '0;
            sumMant     <= '0;
        end else begin
            case (state)
                ACC_IDLE: begin
                    if (in_valid) begin
                        opReg      <= in_data;
                        lastReg    <= in_last;
                        inReadyReg <= 1'b0;
                        state      <= ACC_ALIGN;
                    end
                end
                ACC_ALIGN: begin
                    bigSignR   <= alBigSign;
                    bigExpR    <= alBigExp;
                    bigMantR   <= alBigMant;
                    smallSignR <= alSmallSign;
                    smallMantR <= alSmallMant;
                    state      <= ACC_ADD;
                end
                ACC_ADD: begin
                    sumSign <= addSign;
                    sumMant <= addMant;
                    sumExp  <= {2'b00, bigExpR};
                    state   <= ACC_NORM;
                end
                ACC_NORM: begin
                    if (sumMant[24]) begin
                        sumMant <= sumMant >> 1;
                        sumExp  <= sumExp + 10'sd1;
                    end else if (!sumMant[23] && (sumMant != 25'd0)) begin
                        sumMant <= sumMant << 1;
                        sumExp  <= sumExp - 10'sd1;
                    end else begin
                        accReg   <= normResult;
                        countReg <= countReg + COUNT_W'(1);
                        if (lastReg) begin
                            outValidReg <= 1'b1;
                            state       <= ACC_OUT;
                        end else begin
                            inReadyReg <= 1'b1;
                            state      <= ACC_IDLE;
                        end
                    end
                end
                ACC_OUT: begin
                    if (out_ready) begin
                        accReg      <= FP32_POS_ZERO;
                        countReg    <= '0;
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                        state       <= ACC_IDLE;
                    end
                end
                default: begin
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                    state       <= ACC_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign out_data  = accReg;
    assign out_count = countReg;

endmodule

// File: tb/tb_fp32_accumulator.sv
// Self-checking bench for fp32_accumulator: directed cases plus random dot
// products compared against an integer-arithmetic reference of the FP rules.
module tb_fp32_accumulator;

    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [COUNT_W-1:0] out_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] modelAcc = 32'h0;
    int          modelCount = 0;

    always #5 clk = ~clk;

    fp32_accumulator #(.COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Value-level model: align magnitudes as integers, add signed, renormalize.
    function automatic logic [31:0] refSum(input logic [31:0] acc, input logic [31:0] x, output int shifts);
        int     ea, eb, e, d, p, re;
        longint ma, mb, s, m;
        logic   sgn;
        ea = int'(acc[30:23]);
        eb = int'(x[30:23]);
        ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(acc[22:0]);
        mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(x[22:0]);
        if (ea >= eb) begin
            e = ea; d = ea - eb;
            mb = (d >= 25) ? 0 : (mb >> d);
        end else begin
            e = eb; d = eb - ea;
            ma = (d >= 25) ? 0 : (ma >> d);
        end
        if (acc[31]) ma = -ma;
        if (x[31]) mb = -mb;
        s = ma + mb;
        sgn = (s < 0);
        m = sgn ? -s : s;
        shifts = 0;
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 25; i++) if (((m >> i) & 1) == 1) p = i;
        if (p == 24) begin
            shifts = 1;
            m = m >> 1;
        end else begin
            shifts = 23 - p;
            m = m << (23 - p);
        end
        re = e + p - 23;
        if (re > 254) return {sgn, 8'hFF, 23'd0};
        if (re < 1) return 32'h0;
        return {sgn, 8'(re), 23'(m)};
    endfunction

    function automatic logic [31:0] randTerm(input logic [31:0] acc);
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0:       return 32'h0;
            1:       return {1'($urandom), 8'h00, 23'($urandom)};
            2:       return acc ^ 32'h8000_0000;
            3:       return (acc ^ 32'h8000_0000) + 32'($urandom_range(0, 3));
            default: return {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
        endcase
    endfunction

    task automatic checkResetValues(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
    endtask

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Accepts one term, keeps junk on the inputs while busy, and checks latency.
    task automatic sendTerm(input logic [31:0] data, input logic last);
        int          shifts;
        int          busy;
        logic [31:0] expAcc;
        waitReady();
        expAcc = refSum(modelAcc, data, shifts);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(negedge clk);
        in_data  = $urandom;
        in_last  = 1'($urandom);
        busy = 0;
        while (!in_ready && !out_valid && busy < 100) begin
            out_ready = 1'($urandom);
            busy++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        modelAcc = expAcc;
        modelCount++;
        check("busy_cycles", 32'(busy), 32'(shifts + 3));
        check("done_out_valid", 32'(out_valid), 32'(last));
        check("done_in_ready", 32'(in_ready), 32'(!last));
    endtask

    task automatic readResult(input int hold);
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", out_data, modelAcc);
        check("out_count", 32'(out_count), 32'(modelCount & 32'hFFFF));
        in_valid = 1'b1;
        in_data  = $urandom;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, modelAcc);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
        check("clr_data", out_data, 32'h0);
        check("clr_count", 32'(out_count), 32'd0);
        in_valid = 1'b0;
        modelAcc = 32'h0;
        modelCount = 0;
    endtask

    task automatic directedPair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want, input string tag);
        sendTerm(a, 1'b0);
        sendTerm(b, 1'b1);
        check({tag, "_sum"}, out_data, want);
        check({tag, "_count"}, 32'(out_count), 32'd2);
        readResult(0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 32'h0;
        in_last = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkResetValues("reset");

        directedPair(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, "one_plus_two");
        directedPair(32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, "cancel");
        directedPair(32'h3FC0_0000, 32'hBFBF_FFFF, 32'h3400_0000, "deep_norm");
        directedPair(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
        directedPair(32'h00C0_0000, 32'h8080_0000, 32'h0000_0000, "underflow");

        sendTerm(32'h4040_0000, 1'b1);
        check("single_sum", out_data, 32'h4040_0000);
        readResult(5);

        // Reset while the second term is normalizing.
        sendTerm(32'h3FC0_0000, 1'b0);
        waitReady();
        in_valid = 1'b1;
        in_data  = 32'hBFBF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetValues("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        modelAcc = 32'h0;
        modelCount = 0;
        checkResetValues("post_reset");
        sendTerm(32'h3F80_0000, 1'b1);
        check("after_reset_sum", out_data, 32'h3F80_0000);
        check("after_reset_count", 32'(out_count), 32'd1);
        readResult(0);

        for (int t = 0; t < 150; t++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                sendTerm(randTerm(modelAcc), 1'(i == len - 1));
            end
            readResult($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
